mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter sharing the single instruction/data memory port between the multicycle core (port 0) and the program loader/debug DMA (port 1). Each requester uses a req/ack handshake; the arbiter serializes transactions onto one variable-latency memory handshake and returns read data and completion to the granted requester. A timeout counter ends any access the memory never acknowledges, so neither requester hangs.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum BUSY cycles without mem_ack before abort (≥2)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets all state
- m0_req, m1_req  in  1  transaction request; held high until matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read; sampled at grant
- m0_addr, m1_addr  in  AW  address; sampled at grant
- m0_wdata, m1_wdata  in  DW  write data; sampled at grant
- m0_rdata, m1_rdata  out  DW  registered read data; valid in ack cycle, held until the port's next ack
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  high with ack when the access timed out
- mem_req  out  1  memory request, high for the whole BUSY state
- mem_we  out  1  latched write enable
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data, valid when mem_ack = 1
- mem_ack  in  1  memory completion, may be combinational with mem_req
- grant  out  2  one-hot owner: 01 = port 0, 10 = port 1, 00 = idle

## Operation
- States: IDLE, BUSY0, BUSY1. Reset → IDLE.
- Reset values: all outputs 0, last-served pointer = 1 (port 0 wins the first tie), timeout counter 0.
- IDLE: eligible port = mN_req high and mN_ack not high this cycle (the acked port's req in its ack cycle is ignored).
  - One eligible → grant it. Both eligible → grant the port ≠ last-served. None → stay.
  - On grant: latch we/addr/wdata of the winner into mem_* registers, clear counter, go BUSYn.
- BUSYn: mem_req = 1, grant one-hot n, mem_* stable for the whole state.
  - mem_ack = 1 → capture mem_rdata into mN_rdata (writes also capture it, ignored), next cycle mN_ack = 1, mN_err = 0, last-served = n, go IDLE.
  - mem_ack = 0, counter = TIMEOUT−1 → abort: next cycle mN_ack = 1, mN_err = 1, mN_rdata = 0, last-served = n, go IDLE.
  - Otherwise counter increments.
- A drop of mN_req during BUSYn is ignored; the transaction completes and is acked.
- Requests from the non-granted port are held off; no request is ever lost while req stays high.
- Reset mid-transaction: mem_req and grant drop to 0 after the reset edge, no ack or err issued, latched data discarded.

## Timing
- Uncontended read: req at cycle t (IDLE) → BUSY, mem_req = 1 at t+1 → combinational mem_ack at t+1 → mN_ack and mN_rdata at t+2. Minimum 2-cycle latency, then 1 IDLE cycle; peak throughput one transaction per 2 cycles.
- Memory ack after k BUSY cycles (k ≥ 1) → requester ack k+1 cycles after req.
- Timeout: mem_req high exactly TIMEOUT cycles, ack+err the next cycle.
- Ack cycle is IDLE: the other port, if requesting, is granted in that same cycle (mem_req back high the next cycle).
- Outputs mN_ack, mN_err, mN_rdata, grant, mem_* are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset = 0 three cycles with both reqs high → grant = 00, mem_req = 0, acks 0; release → port 0 granted first.
- Single read: m0 read addr 0x0000_0040, memory acks same cycle with 0xDEAD_BEEF → m0_ack pulse at t+2, m0_rdata = 0xDEAD_BEEF, m0_err = 0, m1 untouched.
- Contention: both ports request continuously, memory 3-cycle latency → grants alternate 01,10,01,10; each port receives one ack per two transactions; no port is starved.
- Write latch: m1 write addr 0x10, data 0x1234_5678, change m1_addr/wdata during BUSY1 → mem_addr = 0x10, mem_wdata = 0x1234_5678 held until m1_ack.
- Timeout: TIMEOUT = 16, memory never acks → mem_req high 16 cycles, then m0_ack = 1, m0_err = 1, m0_rdata = 0; port 1 pending request granted in the ack cycle.
- Reset mid-op: reset = 0 in BUSY0 cycle 2 → next cycle mem_req = 0, grant = 00, no m0_ack; after release, normal arbitration with port 0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter that shares one variable-latency
// memory handshake between the core (port 0) and the loader/debug DMA (port 1).
// Ports:
//   clk, reset              clock and synchronous active-low reset
//   mN_req/we/addr/wdata    per-port request; fields are sampled at grant
//   mN_rdata/ack/err        registered completion: read data, ack pulse, timeout flag
//   mem_req/we/addr/wdata   latched memory request, held for the whole BUSY state
//   mem_rdata/mem_ack       memory response (mem_ack may be combinational)
//   grant                   one-hot owner, 00 when idle
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          elig0, elig1, expire;

  logic          m0_ack_d, m1_ack_d, m0_err_d, m1_err_d;
  logic [DW-1:0] m0_rdata_d, m1_rdata_d;
  logic          mem_req_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic [1:0]    grant_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a port just acked is ignored for one cycle; ties go away from last_q
  always_comb begin
    state_d = state_q;
    elig0   = m0_req && !m0_ack;
    elig1   = m1_req && !m1_ack;
    expire  = !mem_ack && (cnt_q == CW'(TIMEOUT - 1));
    case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || last_q)) state_d = BUSY0;
        else if (elig1)                  state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (mem_ack || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and round-robin pointer
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata;
    m1_rdata_d  = m1_rdata;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_req_d   = (state_d != IDLE);
    grant_d     = {state_d == BUSY1, state_d == BUSY0};
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (state_d == BUSY0) begin
          mem_we_d    = m0_we;
          mem_addr_d  = m0_addr;
          mem_wdata_d = m0_wdata;
        end else if (state_d == BUSY1) begin
          mem_we_d    = m1_we;
          mem_addr_d  = m1_addr;
          mem_wdata_d = m1_wdata;
        end
      end
      BUSY0: begin
        if (mem_ack) begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = mem_rdata;
          last_d     = 1'b0;
        end else if (expire) begin
          m0_ack_d   = 1'b1;
          m0_err_d   = 1'b1;
          m0_rdata_d = '0;
          last_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BUSY1: begin
        if (mem_ack) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = mem_rdata;
          last_d     = 1'b1;
        end else if (expire) begin
          m1_ack_d   = 1'b1;
          m1_err_d   = 1'b1;
          m1_rdata_d = '0;
          last_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Output and datapath registers; last_q resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      last_q    <= 1'b1;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant     <= 2'b00;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      m0_ack    <= m0_ack_d;
      m1_ack    <= m1_ack_d;
      m0_err    <= m0_err_d;
      m1_err    <= m1_err_d;
      m0_rdata  <= m0_rdata_d;
      m1_rdata  <= m1_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      grant     <= grant_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the round-robin arbiter and a latency-programmable memory.
module tb_mem_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [DW-1:0] KEY   = 32'h5A5A_C3C3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req_v = 2'b00;
  logic [1:0]    we_v = 2'b00;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wd_v [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant;
  wire  [1:0]    ack_v = {m1_ack, m0_ack};
  wire  [1:0]    err_v = {m1_err, m0_err};

  int            checks = 0;
  int            errors = 0;

  // Memory: acks in BUSY cycle number lat (1-based); lat = 0 never acks
  int            lat = 1;
  int            busy_cnt = 0;
  logic          fixed_en = 1'b0;
  logic [DW-1:0] fixed_val = '0;

  assign mem_ack   = mem_req && (lat != 0) && (busy_cnt == lat - 1);
  assign mem_rdata = fixed_en ? fixed_val : (mem_addr ^ KEY);

  always @(posedge clk) busy_cnt <= mem_req ? busy_cnt + 1 : 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (req_v[0]),
    .m0_we     (we_v[0]),
    .m0_addr   (addr_v[0]),
    .m0_wdata  (wd_v[0]),
    .m0_rdata  (m0_rdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_req    (req_v[1]),
    .m1_we     (we_v[1]),
    .m1_addr   (addr_v[1]),
    .m1_wdata  (wd_v[1]),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .grant     (grant)
  );

  // Called at a negedge; returns at a negedge with reset released and ports idle
  task automatic do_reset();
    reset     = 1'b0;
    req_v     = 2'b00;
    we_v      = 2'b00;
    addr_v[0] = '0; addr_v[1] = '0;
    wd_v[0]   = '0; wd_v[1]   = '0;
    lat       = 1;
    fixed_en  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_v = 2'b11;
    we_v  = 2'b00;
    addr_v[0] = 32'h4; addr_v[1] = 32'h8;
    wd_v[0] = '0; wd_v[1] = '0;
    lat = 1;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if (ack_v !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b exp 00", ack_v); end
    checks++; if (err_v !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
      errors++; $display("FAIL reset_err_rdata: err %b rd0 %h rd1 %h exp all 0", err_v, m0_rdata, m1_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b exp 01", grant); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_first_mem_req: got %b exp 1", mem_req); end
    do_reset();
  endtask

  task automatic test_single_read();
    fixed_en  = 1'b1;
    fixed_val = 32'hDEAD_BEEF;
    lat       = 1;
    req_v[0]  = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h0000_0040;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || mem_req !== 1'b1) begin
      errors++; $display("FAIL single_busy: grant %b mem_req %b exp 01/1", grant, mem_req);
    end
    checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++; $display("FAIL single_mem_addr: got %h we %b exp 00000040 we 0", mem_addr, mem_we);
    end
    checks++; if (ack_v !== 2'b00) begin errors++; $display("FAIL single_early_ack: got %b exp 00", ack_v); end
    @(negedge clk);
    checks++; if (ack_v !== 2'b01) begin errors++; $display("FAIL single_ack: got %b exp 01", ack_v); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h exp deadbeef", m0_rdata); end
    checks++; if (err_v !== 2'b00 || m1_rdata !== '0 || grant !== 2'b00) begin
      errors++; $display("FAIL single_side: err %b rd1 %h grant %b exp 00/0/00", err_v, m1_rdata, grant);
    end
    req_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (ack_v !== 2'b00 || m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_pulse_hold: ack %b rd0 %h exp 00/deadbeef", ack_v, m0_rdata);
    end
    do_reset();
  endtask

  task automatic test_contention();
    logic [1:0] gseq [4];
    logic [1:0] pg;
    int ng, a0, a1;
    ng = 0; a0 = 0; a1 = 0; pg = 2'b00;
    for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
    lat = 3;
    we_v = 2'b00; addr_v[0] = 32'h100; addr_v[1] = 32'h200;
    req_v = 2'b11;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (pg == 2'b00 && grant != 2'b00 && ng < 4) begin gseq[ng] = grant; ng++; end
      pg = grant;
      a0 += int'(ack_v[0]);
      a1 += int'(ack_v[1]);
    end
    checks++; if (ng != 4) begin errors++; $display("FAIL contention_grant_count: got %0d exp 4", ng); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gseq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL contention_order[%0d]: got %b exp %b", i, gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    checks++; if (a0 != 2 || a1 != 2) begin errors++; $display("FAIL contention_acks: got %0d/%0d exp 2/2", a0, a1); end
    checks++; if (m0_rdata !== (32'h100 ^ KEY) || m1_rdata !== (32'h200 ^ KEY)) begin
      errors++; $display("FAIL contention_rdata: got %h/%h exp %h/%h", m0_rdata, m1_rdata, 32'h100 ^ KEY, 32'h200 ^ KEY);
    end
    do_reset();
  endtask

  task automatic test_write_latch();
    lat = 4;
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h10; wd_v[1] = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 ||
          mem_wdata !== 32'h1234_5678 || ack_v !== 2'b00) begin
        errors++;
        $display("FAIL write_hold cyc %0d: grant %b req %b we %b addr %h wdata %h ack %b exp 10/1/1/00000010/12345678/00",
                 c, grant, mem_req, mem_we, mem_addr, mem_wdata, ack_v);
      end
      addr_v[1] = $urandom;
      wd_v[1]   = $urandom;
    end
    @(negedge clk);
    checks++; if (ack_v !== 2'b10 || err_v !== 2'b00 || grant !== 2'b00) begin
      errors++; $display("FAIL write_ack: ack %b err %b grant %b exp 10/00/00", ack_v, err_v, grant);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int hi;
    logic got;
    lat = 1;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h80;
    repeat (2) @(negedge clk);
    req_v[0] = 1'b0;
    checks++; if (m0_rdata !== (32'h80 ^ KEY)) begin
      errors++; $display("FAIL timeout_pre_rdata: got %h exp %h", m0_rdata, 32'h80 ^ KEY);
    end
    @(negedge clk);
    lat = 0;
    req_v[0] = 1'b1; addr_v[0] = 32'h84;
    hi = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req) hi++;
      if (c == 0) begin req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h90; end
      if (ack_v[0]) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL timeout_no_ack: got no m0_ack within 40 cycles exp ack"); end
    checks++; if (hi != int'(TIMEOUT)) begin errors++; $display("FAIL timeout_req_cycles: got %0d exp %0d", hi, TIMEOUT); end
    checks++; if (err_v !== 2'b01 || ack_v !== 2'b01) begin
      errors++; $display("FAIL timeout_err: err %b ack %b exp 01/01", err_v, ack_v);
    end
    checks++; if (m0_rdata !== '0) begin errors++; $display("FAIL timeout_rdata: got %h exp 0", m0_rdata); end
    req_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b10 || mem_req !== 1'b1 || mem_addr !== 32'h90) begin
      errors++; $display("FAIL timeout_next_grant: grant %b req %b addr %h exp 10/1/00000090", grant, mem_req, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_reset_midop();
    lat = 0;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'hA0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL midop_pre_grant: got %b exp 01", grant); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL midop_drop: mem_req %b grant %b exp 0/00", mem_req, grant);
    end
    checks++; if (ack_v !== 2'b00 || err_v !== 2'b00) begin
      errors++; $display("FAIL midop_no_ack: ack %b err %b exp 00/00", ack_v, err_v);
    end
    reset = 1'b1;
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'hB0;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || ack_v !== 2'b00) begin
      errors++; $display("FAIL midop_regrant: grant %b ack %b exp 01/00", grant, ack_v);
    end
    lat = 1;
    @(negedge clk);
    checks++; if (ack_v !== 2'b01 || err_v !== 2'b00 || m0_rdata !== (32'hA0 ^ KEY)) begin
      errors++; $display("FAIL midop_complete: ack %b err %b rd0 %h exp 01/00/%h", ack_v, err_v, m0_rdata, 32'hA0 ^ KEY);
    end
    do_reset();
  endtask

  // Transaction-level model: owner, cycles spent busy, last served, latched request
  task automatic test_random();
    int            own, cnt, last, win;
    logic          e0, e1;
    logic [1:0]    ack_prev, nack, nerr, exp_g;
    logic [DW-1:0] erd [2];
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wd;
    own = -1; cnt = 0; last = 1; ack_prev = 2'b00;
    erd[0] = '0; erd[1] = '0;
    l_we = 1'b0; l_addr = '0; l_wd = '0;
    lat = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      nack = 2'b00; nerr = 2'b00;
      if (own < 0) begin
        e0  = req_v[0] && !ack_prev[0];
        e1  = req_v[1] && !ack_prev[1];
        win = (e0 && e1) ? 1 - last : e0 ? 0 : e1 ? 1 : -1;
        if (win >= 0) begin
          own = win; cnt = 0;
          l_we = we_v[win]; l_addr = addr_v[win]; l_wd = wd_v[win];
        end
      end else begin
        cnt++;
        if (lat != 0 && cnt == lat) begin
          nack[own] = 1'b1; erd[own] = l_addr ^ KEY; last = own; own = -1;
        end else if (cnt == int'(TIMEOUT)) begin
          nack[own] = 1'b1; nerr[own] = 1'b1; erd[own] = '0; last = own; own = -1;
        end
      end
      exp_g = (own < 0) ? 2'b00 : (own == 0) ? 2'b01 : 2'b10;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rnd_grant cyc %0d: got %b exp %b", cyc, grant, exp_g); end
      checks++; if (mem_req !== 1'(own >= 0)) begin errors++; $display("FAIL rnd_mem_req cyc %0d: got %b exp %b", cyc, mem_req, own >= 0); end
      checks++; if (ack_v !== nack) begin errors++; $display("FAIL rnd_ack cyc %0d: got %b exp %b", cyc, ack_v, nack); end
      checks++; if (err_v !== nerr) begin errors++; $display("FAIL rnd_err cyc %0d: got %b exp %b", cyc, err_v, nerr); end
      checks++; if (m0_rdata !== erd[0] || m1_rdata !== erd[1]) begin
        errors++; $display("FAIL rnd_rdata cyc %0d: got %h/%h exp %h/%h", cyc, m0_rdata, m1_rdata, erd[0], erd[1]);
      end
      if (own >= 0) begin
        checks++;
        if (mem_we !== l_we || mem_addr !== l_addr || mem_wdata !== l_wd) begin
          errors++; $display("FAIL rnd_mem_fields cyc %0d: got %b %h %h exp %b %h %h", cyc, mem_we, mem_addr, mem_wdata, l_we, l_addr, l_wd);
        end
      end
      ack_prev = nack;
      if (errors > 40) break;
      // requester behaviour: hold req until ack; owner may drop req or change fields
      for (int p = 0; p < 2; p++) begin
        if (req_v[p] && nack[p]) begin
          req_v[p] = 1'($urandom_range(0, 1));
          we_v[p] = 1'($urandom_range(0, 1)); addr_v[p] = $urandom; wd_v[p] = $urandom;
        end else if (req_v[p] && own == p) begin
          if ($urandom_range(0, 7) == 0) req_v[p] = 1'b0;
          addr_v[p] = $urandom; wd_v[p] = $urandom; we_v[p] = 1'($urandom_range(0, 1));
        end else if (!req_v[p] && own != p && $urandom_range(0, 2) == 0) begin
          req_v[p] = 1'b1;
          we_v[p] = 1'($urandom_range(0, 1)); addr_v[p] = $urandom; wd_v[p] = $urandom;
        end
      end
      if ($urandom_range(0, 15) == 0) lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 5));
    end
    do_reset();
  endtask

  initial begin
    addr_v[0] = '0; addr_v[1] = '0;
    wd_v[0] = '0; wd_v[1] = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_latch();
    test_timeout();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
